read_superpixel: RTL and testbench

//   Read-back engine for the VGA frame-buffer RAM: the read-side counterpart of draw_superpixel.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/read_superpixel_if.sv | 23 ++
 rtl/superpixel2pixel.sv | 16 +
 rtl/read_superpixel.sv | 94 +++++++++
 tb/tb_read_superpixel.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared frame-buffer geometry, colour ids and address helpers
package vga_pkg;
    localparam int SPIXEL_X_WIDTH = 5;
    localparam int SPIXEL_Y_WIDTH = 5;
    localparam int SPIXEL_X_MAX   = 32;
    localparam int SPIXEL_Y_MAX   = 24;
    localparam int PIXEL_X_WIDTH  = 10;
    localparam int PIXEL_Y_WIDTH  = 9;
    localparam int PIXEL_X_MAX    = 640;
    localparam int PIXEL_Y_MAX    = 480;
    localparam int ADDR_WIDTH     = 19;
    localparam int COLOR_ID_WIDTH = 8;
    localparam int SP_W      = PIXEL_X_MAX / SPIXEL_X_MAX;
    localparam int SP_H      = PIXEL_Y_MAX / SPIXEL_Y_MAX;
    localparam int SP_PIXELS = SP_W * SP_H;
    localparam logic [COLOR_ID_WIDTH-1:0] COLOR_BG     = 8'hff;
    localparam logic [COLOR_ID_WIDTH-1:0] COLOR_SPRITE = 8'h0f;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rsp_state_t;
    function automatic logic [ADDR_WIDTH-1:0] xy2addr(
        input logic [PIXEL_X_WIDTH-1:0] px,
        input logic [PIXEL_Y_WIDTH-1:0] py
    );
        return ADDR_WIDTH'(py) * ADDR_WIDTH'(PIXEL_X_MAX) + ADDR_WIDTH'(px);
    endfunction
    function automatic logic spixel_in_range(
        input logic [SPIXEL_X_WIDTH-1:0] sx,
        input logic [SPIXEL_Y_WIDTH-1:0] sy
    );
        return (int'(sx) < SPIXEL_X_MAX) && (int'(sy) < SPIXEL_Y_MAX);
    endfunction
endpackage

// File: rtl/read_superpixel_if.sv
// read_superpixel_if: request/result handshake plus the RAM read port of the superpixel reader
interface read_superpixel_if;
    import vga_pkg::*;
    logic [SPIXEL_X_WIDTH-1:0] x;
    logic [SPIXEL_Y_WIDTH-1:0] y;
    logic                      ireq;
    logic                      obusy;
    logic                      odone;
    logic [COLOR_ID_WIDTH-1:0] ocolor;
    logic                      ouniform;
    logic                      oerr;
    logic [ADDR_WIDTH-1:0]     oaddr;
    logic                      ordreq;
    logic [COLOR_ID_WIDTH-1:0] irdata;
    modport slave (
        input  x, y, ireq, irdata,
        output obusy, odone, ocolor, ouniform, oerr, oaddr, ordreq
    );
    modport master (
        output x, y, ireq, irdata,
        input  obusy, odone, ocolor, ouniform, oerr, oaddr, ordreq
    );
endinterface

// File: rtl/superpixel2pixel.sv
// superpixel2pixel: physical top-left and bottom-right corners of a logical superpixel
module superpixel2pixel
    import vga_pkg::*;
(
    input  logic [SPIXEL_X_WIDTH-1:0] sx,
    input  logic [SPIXEL_Y_WIDTH-1:0] sy,
    output logic [PIXEL_X_WIDTH-1:0]  tlx,
    output logic [PIXEL_X_WIDTH-1:0]  brx,
    output logic [PIXEL_Y_WIDTH-1:0]  tly,
    output logic [PIXEL_Y_WIDTH-1:0]  bry
);
    assign tlx = PIXEL_X_WIDTH'(sx) * PIXEL_X_WIDTH'(SP_W);
    assign tly = PIXEL_Y_WIDTH'(sy) * PIXEL_Y_WIDTH'(SP_H);
    assign brx = tlx + PIXEL_X_WIDTH'(SP_W - 1);
    assign bry = tly + PIXEL_Y_WIDTH'(SP_H - 1);
endmodule

// File: rtl/read_superpixel.sv
// read_superpixel: scans one superpixel tile from frame RAM, returning its colour and uniformity
module read_superpixel
    import vga_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    read_superpixel_if.slave bus
);
    localparam int CNT_W = $clog2(SP_PIXELS + 1);
    localparam logic [RD_LATENCY-1:0] VLD_TOP = RD_LATENCY'(1) << (RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(PIXEL_X_MAX - (SP_W - 1));

    rsp_state_t state, state_nx;
    logic [SPIXEL_X_WIDTH-1:0] x_q;
    logic [SPIXEL_Y_WIDTH-1:0] y_q;
    logic [PIXEL_X_WIDTH-1:0]  px, tlx, brx;
    logic [PIXEL_Y_WIDTH-1:0]  py, tly, bry;
    logic [RD_LATENCY-1:0]     vld;
    logic [CNT_W-1:0]          ret_cnt;
    logic in_range, accept, row_end, last_px, rd_valid;

    // Corners come from the live request while idle so the first address is ready on the next cycle
    superpixel2pixel u_s2p (
        .sx (state == IDLE ? bus.x : x_q),
        .sy (state == IDLE ? bus.y : y_q),
        .tlx(tlx),
        .brx(brx),
        .tly(tly),
        .bry(bry)
    );

    assign in_range = spixel_in_range(bus.x, bus.y);
    assign accept   = state == IDLE && bus.ireq;
    assign row_end  = px == brx;
    assign last_px  = row_end && py == bry;
    assign rd_valid = vld[RD_LATENCY-1];

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx     = state;
        bus.obusy    = state == ISSUE || state == DRAIN;
        bus.ordreq   = state == ISSUE;
        bus.odone    = state == DONE;
        unique case (state)
            IDLE:    state_nx = bus.ireq ? (in_range ? ISSUE : DONE) : IDLE;
            ISSUE:   state_nx = last_px ? DRAIN : ISSUE;
            DRAIN:   state_nx = |(vld & ~VLD_TOP) ? DRAIN : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            px           <= '0;
            py           <= '0;
            vld          <= '0;
            ret_cnt      <= '0;
            bus.oaddr    <= '0;
            bus.ocolor   <= '0;
            bus.ouniform <= 1'b0;
            bus.oerr     <= 1'b0;
        end else begin
            vld <= (vld << 1) | RD_LATENCY'(bus.ordreq);
            if (accept) begin
                bus.oerr <= !in_range;
                ret_cnt  <= '0;
            end
            if (accept && in_range) begin
                x_q       <= bus.x;
                y_q       <= bus.y;
                px        <= tlx;
                py        <= tly;
                bus.oaddr <= xy2addr(tlx, tly);
            end else if (state == ISSUE && !last_px) begin
                px        <= row_end ? tlx : px + PIXEL_X_WIDTH'(1);
                py        <= row_end ? py + PIXEL_Y_WIDTH'(1) : py;
                bus.oaddr <= bus.oaddr + (row_end ? ROW_STEP : ADDR_WIDTH'(1));
            end
            if (rd_valid) begin
                ret_cnt      <= ret_cnt + CNT_W'(1);
                bus.ocolor   <= ret_cnt == '0 ? bus.irdata : bus.ocolor;
                bus.ouniform <= ret_cnt == '0 ? 1'b1 : bus.ouniform && bus.irdata == bus.ocolor;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (state == DONE && !bus.oerr) |-> ret_cnt == CNT_W'(SP_PIXELS));
endmodule

// File: tb/tb_read_superpixel.sv
// tb_read_superpixel: drives L=1 and L=2 readers against a RAM model and a tile-level reference
module tb_read_superpixel;
    import vga_pkg::*;

    logic clk, rst, ireq, sel;
    logic [4:0] x, y;
    logic [7:0] mem [PIXEL_X_MAX*PIXEL_Y_MAX];
    logic [7:0] r1, r2a, r2b;
    logic [7:0] exp_col [2];
    logic       exp_uni [2];
    logic [18:0] got_addr [$];
    int cyc = 0, n_done = 0, done_cyc = 0, checks = 0, errors = 0;
    logic o_busy, o_done, o_uni, o_err, o_req;
    logic [7:0]  o_col;
    logic [18:0] o_addr;

    read_superpixel_if b1 ();
    read_superpixel_if b2 ();

    read_superpixel #(.RD_LATENCY(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
    read_superpixel #(.RD_LATENCY(2)) d2 (.clk(clk), .rst(rst), .bus(b2));

    assign b1.x = x;
    assign b1.y = y;
    assign b2.x = x;
    assign b2.y = y;
    assign b1.ireq = ireq && !sel;
    assign b2.ireq = ireq && sel;
    assign b1.irdata = r1;
    assign b2.irdata = r2b;
    assign o_busy = sel ? b2.obusy : b1.obusy;
    assign o_done = sel ? b2.odone : b1.odone;
    assign o_uni  = sel ? b2.ouniform : b1.ouniform;
    assign o_err  = sel ? b2.oerr : b1.oerr;
    assign o_req  = sel ? b2.ordreq : b1.ordreq;
    assign o_col  = sel ? b2.ocolor : b1.ocolor;
    assign o_addr = sel ? b2.oaddr : b1.oaddr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rd(input logic [18:0] a);
        return (int'(a) < PIXEL_X_MAX * PIXEL_Y_MAX) ? mem[int'(a)] : 8'h00;
    endfunction

    // Idle cycles return junk so only tagged samples may influence the result
    always @(posedge clk) begin
        r1  <= b1.ordreq ? rd(b1.oaddr) : 8'($urandom);
        r2a <= b2.ordreq ? rd(b2.oaddr) : 8'($urandom);
        r2b <= r2a;
    end

    always @(negedge clk) begin
        if (o_req) got_addr.push_back(o_addr);
        if (o_done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_color"}, 32'(o_col), 0);
        chk({tag, "_uniform"}, 32'(o_uni), 0);
        chk({tag, "_err"}, 32'(o_err), 0);
        chk({tag, "_rdreq"}, 32'(o_req), 0);
        chk({tag, "_addr"}, 32'(o_addr), 0);
    endtask

    task automatic fill_tile(input int sx, input int sy, input logic [7:0] c);
        for (int py = 0; py < SP_H; py++)
            for (int px = 0; px < SP_W; px++)
                mem[(sy * SP_H + py) * PIXEL_X_MAX + sx * SP_W + px] = c;
    endtask

    // mode 0: plain request; 1: stray ireq mid-scan and on the odone cycle; 2: reset at beat 150
    task automatic run_req(input int rx, input int ry, input int mode);
        int t0, nb, mism, k;
        logic seen, in;
        logic [7:0] ec;
        logic eu;
        got_addr.delete();
        n_done = 0;
        nb = 0;
        seen = 1'b0;
        in = rx < SPIXEL_X_MAX && ry < SPIXEL_Y_MAX;
        @(posedge clk);
        #1;
        x = 5'(rx);
        y = 5'(ry);
        ireq = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 ireq = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            seen = o_done;
            nb += int'(o_req);
            if (mode == 1) begin
                ireq = nb == 100;
                x = 5'(rx + 1);
            end
            if (mode == 2 && nb == 150) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk_reset_outputs("midscan_rst");
                rst = 1'b0;
                repeat (5) @(negedge clk);
                chk("rst_beats", 32'(got_addr.size()), 150);
                chk("rst_done", 32'(n_done), 0);
                exp_col[0] = 8'h00;
                exp_col[1] = 8'h00;
                exp_uni[0] = 1'b0;
                exp_uni[1] = 1'b0;
                return;
            end
        end
        if (mode == 1 && seen) begin
            x = 5'(rx);
            ireq = 1'b1;
            @(negedge clk);
            ireq = 1'b0;
        end
        repeat (6) @(negedge clk);
        chk("done_cnt", 32'(n_done), 1);
        chk("done_lat", 32'(done_cyc - t0), in ? 32'(SP_PIXELS + 2 + int'(sel)) : 1);
        chk("busy_after", 32'(o_busy), 0);
        chk("err", 32'(o_err), 32'(!in));
        if (in) begin
            ec = mem[(ry * SP_H) * PIXEL_X_MAX + rx * SP_W];
            eu = 1'b1;
            mism = 0;
            k = 0;
            for (int py = ry * SP_H; py < (ry + 1) * SP_H; py++)
                for (int px = rx * SP_W; px < (rx + 1) * SP_W; px++) begin
                    if (mem[py * PIXEL_X_MAX + px] != ec) eu = 1'b0;
                    if (k >= got_addr.size() || int'(got_addr[k]) != py * PIXEL_X_MAX + px) mism++;
                    k++;
                end
            exp_col[sel] = ec;
            exp_uni[sel] = eu;
            chk("beats", 32'(got_addr.size()), SP_PIXELS);
            chk("addr_seq", 32'(mism), 0);
        end else begin
            chk("err_beats", 32'(got_addr.size()), 0);
        end
        chk("color", 32'(o_col), 32'(exp_col[sel]));
        chk("uniform", 32'(o_uni), 32'(exp_uni[sel]));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int rx, ry;
        logic [7:0] c;
        rst = 1'b1;
        ireq = 1'b0;
        x = '0;
        y = '0;
        sel = 1'b0;
        exp_col[0] = 8'h00;
        exp_col[1] = 8'h00;
        exp_uni[0] = 1'b0;
        exp_uni[1] = 1'b0;
        for (int i = 0; i < PIXEL_X_MAX * PIXEL_Y_MAX; i++) mem[i] = COLOR_BG;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_l1");
        sel = 1'b1;
        #1;
        chk_reset_outputs("reset_l2");
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            fill_tile(0, 0, COLOR_BG);
            run_req(0, 0, 0);
            chk("t1_first_addr", 32'(got_addr.size() > 0 ? got_addr[0] : '1), 0);
            chk("t1_last_addr", 32'(got_addr.size() > 0 ? got_addr[$] : '1), 12179);
            chk("t1_color", 32'(o_col), 32'hff);
            fill_tile(5, 3, COLOR_SPRITE);
            mem[79 * PIXEL_X_MAX + 119] = COLOR_BG;
            run_req(5, 3, 0);
            chk("t2_first_addr", 32'(got_addr.size() > 0 ? got_addr[0] : '1), 38500);
            chk("t2_uniform", 32'(o_uni), 0);
            fill_tile(31, 23, 8'($urandom));
            run_req(31, 23, 0);
            chk("t3_last_addr", 32'(got_addr.size() > 0 ? got_addr[$] : '1), 307199);
            run_req(0, 24, 0);
            run_req(31, 31, 0);
            run_req(2, 2, 1);
            for (int n = 0; n < 4; n++) begin
                rx = int'($urandom_range(0, SPIXEL_X_MAX - 1));
                ry = int'($urandom_range(0, SPIXEL_Y_MAX - 1));
                c = 8'($urandom);
                fill_tile(rx, ry, c);
                if ($urandom_range(0, 1) == 1)
                    mem[(ry * SP_H + int'($urandom_range(0, SP_H - 1))) * PIXEL_X_MAX
                        + rx * SP_W + int'($urandom_range(0, SP_W - 1))] = c ^ 8'($urandom_range(1, 255));
                run_req(rx, ry, 0);
            end
            fill_tile(6, 6, 8'h33);
            mem[(6 * SP_H + 10) * PIXEL_X_MAX + 6 * SP_W + 4] = 8'h44;
            run_req(6, 6, 2);
            fill_tile(4, 4, COLOR_SPRITE);
            run_req(4, 4, 0);
            chk("post_rst_color", 32'(o_col), 32'h0f);
            chk("post_rst_uniform", 32'(o_uni), 1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
